uart_tx_model: RTL and testbench

//   Co-sim testbench UART transmitter: buffers bytes from a valid/ready push interface in a FIFO
//   and serializes them onto uart_txd as 8N1-style frames (start, LSB-first payload, stop bits).

---
 rtl/uart_tx_model.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_model.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_model.sv
// UART transmit model: byte FIFO behind a valid/ready push port, serialized as
// start / LSB-first payload / stop frames on uart_txd, plus a timed break.
// Ports: clk, reset (sync, active high), tx_en (allow new frames),
//   tx_valid/tx_data/tx_ready (push), tx_break (break request, IDLE only),
//   uart_txd (serial out, idle high), tx_busy (FSM not idle), fifo_count.
module uart_tx_model #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_en,
  input  logic                          tx_valid,
  input  logic [PAYLOAD_BITS-1:0]       tx_data,
  output logic                          tx_ready,
  input  logic                          tx_break,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int STOP_CYC = STOP_BITS * CPB;
  localparam int BRK_CYC  = 2 * (1 + PAYLOAD_BITS + STOP_BITS) * CPB;
  localparam int TW       = $clog2(BRK_CYC);
  localparam int BW       = $clog2(PAYLOAD_BITS);

  localparam logic [TW-1:0] CPB_END  = TW'(CPB - 1);
  localparam logic [TW-1:0] STOP_END = TW'(STOP_CYC - 1);
  localparam logic [TW-1:0] BRK_END  = TW'(BRK_CYC - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(PAYLOAD_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  if (CPB < 2) begin : g_cpb_chk
    $error("uart_tx_model: CLK_HZ/BIT_RATE must be at least 2");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_pl_chk
    $error("uart_tx_model: PAYLOAD_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
    $error("uart_tx_model: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fd_chk
    $error("uart_tx_model: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  state_t state_q, state_d;

  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] sh_q, sh_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    push, pop;

  // Ready follows the registered count, so a full FIFO refuses a push
  // even in the cycle it pops.
  assign tx_ready   = !reset && (cnt_q < DEPTH_C);
  assign push       = tx_valid && tx_ready;
  assign cnt_d      = cnt_q + CW'(push) - CW'(pop);
  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign fifo_count = cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // IDLE also starts on a push arriving this cycle; the byte is in the
  // FIFO by the time LOAD pops it, giving a two-cycle push-to-start.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (tx_break) begin
          state_d = S_BREAK;
          tmr_d   = '0;
          txd_d   = 1'b0;
        end else if (tx_en && (cnt_q != '0 || push)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        pop     = 1'b1;
        sh_d    = mem_q[rd_q];
        tmr_d   = '0;
        state_d = S_START;
        txd_d   = 1'b0;
      end
      S_START: begin
        if (tmr_q == CPB_END) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          txd_d   = sh_q[0];
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DATA: begin
        if (tmr_q == CPB_END) begin
          tmr_d = '0;
          if (bit_q == BIT_END) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
            sh_d  = sh_q >> 1;
            txd_d = sh_q[1];
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (tmr_q == STOP_END) begin
          tmr_d   = '0;
          state_d = (tx_en && cnt_q != '0) ? S_LOAD : S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_BREAK: begin
        if (tmr_q == BRK_END) begin
          tmr_d   = '0;
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_model.sv
// Directed bench for uart_tx_model at CPB=10: 8N1 instance plus a
// 7-bit / 2-stop instance, checked with immediate assertions.
module tb_uart_tx_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tx_en, tx_valid, tx_break;
  logic [7:0] tx_data;
  logic       tx_ready, uart_txd, tx_busy;
  logic [4:0] fifo_count;

  logic       tx_en2, tx_valid2, tx_break2;
  logic [6:0] tx_data2;
  logic       tx_ready2, txd2, busy2;
  logic [4:0] count2;

  uart_tx_model #(
    .BIT_RATE(5_000_000), .CLK_HZ(50_000_000),
    .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut (
    .clk(clk), .reset(reset), .tx_en(tx_en),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_break(tx_break), .uart_txd(uart_txd), .tx_busy(tx_busy),
    .fifo_count(fifo_count)
  );

  uart_tx_model #(
    .BIT_RATE(5_000_000), .CLK_HZ(50_000_000),
    .PAYLOAD_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) u_dut2 (
    .clk(clk), .reset(reset), .tx_en(tx_en2),
    .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready2),
    .tx_break(tx_break2), .uart_txd(txd2), .tx_busy(busy2),
    .fifo_count(count2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic line(input int inst);
    return (inst == 2) ? txd2 : uart_txd;
  endfunction

  task automatic wait_start(input int inst, input int limit, output int t);
    int n;
    n = 0;
    while (line(inst) !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    chk("start_seen", 32'(line(inst) === 1'b0), 32'd1);
    t = cyc;
  endtask

  // Entered off cycles after the first low cycle; leaves at mid last stop bit.
  task automatic rx_frame(input int inst, input int nb, input int ns,
                          input int off, output logic [7:0] b);
    b = '0;
    tick(5 - off);
    chk("start_bit", 32'(line(inst)), 32'd0);
    for (int i = 0; i < nb; i++) begin
      tick(10);
      b[i] = line(inst);
    end
    for (int i = 0; i < ns; i++) begin
      tick(10);
      chk("stop_bit", 32'(line(inst)), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp_b;
    int t, tp, lows;

    reset = 1'b1; tx_en = 1'b0; tx_valid = 1'b0;
    tx_break = 1'b0; tx_data = '0;
    tx_en2 = 1'b0; tx_valid2 = 1'b0; tx_break2 = 1'b0; tx_data2 = '0;

    // reset
    tick(3);
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    reset = 1'b0;
    tx_en = 1'b1;
    tick(1);
    chk("ready_after_rst", 32'(tx_ready), 32'd1);
    chk("idle_txd", 32'(uart_txd), 32'd1);

    // single byte 0x55, exact latency
    tick(2);
    tx_valid = 1'b1; tx_data = 8'h55;
    tick(1);
    tx_valid = 1'b0;
    chk("n1_count", 32'(fifo_count), 32'd1);
    chk("n1_busy", 32'(tx_busy), 32'd1);
    chk("n1_txd", 32'(uart_txd), 32'd1);
    tick(1);
    chk("n2_count", 32'(fifo_count), 32'd0);
    chk("n2_txd", 32'(uart_txd), 32'd0);
    rx_frame(1, 8, 1, 0, b);
    chk("byte_55", 32'(b), 32'h55);
    tick(4);
    chk("n101_busy", 32'(tx_busy), 32'd1);
    tick(1);
    chk("n102_busy", 32'(tx_busy), 32'd0);
    chk("n102_txd", 32'(uart_txd), 32'd1);

    // loopback "HI\n", frames 101 cycles apart
    tick(5);
    tx_valid = 1'b1; tx_data = 8'h48;
    tick(1);
    tx_data = 8'h49;
    tick(1);
    tx_data = 8'h0a;
    chk("hi_latency", 32'(uart_txd), 32'd0);
    t = cyc;
    tick(1);
    tx_valid = 1'b0;
    rx_frame(1, 8, 1, 1, b);
    chk("hi_byte0", 32'(b), 32'h48);
    tp = t;
    wait_start(1, 20, t);
    chk("hi_gap1", 32'(t - tp), 32'd101);
    rx_frame(1, 8, 1, 0, b);
    chk("hi_byte1", 32'(b), 32'h49);
    tp = t;
    wait_start(1, 20, t);
    chk("hi_gap2", 32'(t - tp), 32'd101);
    rx_frame(1, 8, 1, 0, b);
    chk("hi_byte2", 32'(b), 32'h0a);

    // backpressure: 17 pushes with tx_en low
    tx_en = 1'b0;
    tick(10);
    for (int i = 0; i < 17; i++) begin
      tx_valid = 1'b1;
      tx_data  = (i == 16) ? 8'hEE : 8'(i * 37 + 5);
      if (i == 16) chk("bp_ready_full", 32'(tx_ready), 32'd0);
      tick(1);
    end
    tx_valid = 1'b0;
    chk("bp_count16", 32'(fifo_count), 32'd16);
    chk("bp_ready0", 32'(tx_ready), 32'd0);
    chk("bp_held_txd", 32'(uart_txd), 32'd1);
    tx_en = 1'b1;
    tp = 0;
    for (int k = 0; k < 16; k++) begin
      wait_start(1, 20, t);
      if (k == 0) chk("bp_count15", 32'(fifo_count), 32'd15);
      if (k > 0) chk("bp_gap", 32'(t - tp), 32'd101);
      tp = t;
      rx_frame(1, 8, 1, 0, b);
      exp_b = 8'(k * 37 + 5);
      chk("bp_byte", 32'(b), 32'(exp_b));
    end
    chk("bp_count0", 32'(fifo_count), 32'd0);
    lows = 0;
    repeat (150) begin
      tick(1);
      if (uart_txd !== 1'b1) lows++;
    end
    chk("bp_no_17th", 32'(lows), 32'd0);
    chk("bp_idle_busy", 32'(tx_busy), 32'd0);

    // break in IDLE with a byte queued
    tx_en = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h3C;
    tick(1);
    tx_valid = 1'b0;
    tick(2);
    tx_break = 1'b1; tx_en = 1'b1;
    tick(1);
    tx_break = 1'b0;
    chk("brk_first", 32'(uart_txd), 32'd0);
    chk("brk_busy", 32'(tx_busy), 32'd1);
    tick(199);
    chk("brk_last", 32'(uart_txd), 32'd0);
    tick(1);
    chk("brk_end_txd", 32'(uart_txd), 32'd1);
    chk("brk_count", 32'(fifo_count), 32'd1);
    tick(1);
    chk("brk_load_txd", 32'(uart_txd), 32'd1);
    tick(1);
    chk("brk_resume", 32'(uart_txd), 32'd0);
    // break request mid-frame must be ignored
    tx_break = 1'b1;
    rx_frame(1, 8, 1, 0, b);
    tx_break = 1'b0;
    chk("brk_byte", 32'(b), 32'h3C);
    tick(10);
    chk("brk_ignored_txd", 32'(uart_txd), 32'd1);
    chk("brk_ignored_busy", 32'(tx_busy), 32'd0);

    // reset during data bit 3
    tx_valid = 1'b1; tx_data = 8'hF0;
    tick(1);
    tx_data = 8'h5A;
    tick(1);
    tx_valid = 1'b0;
    chk("rm_start", 32'(uart_txd), 32'd0);
    tick(45);
    chk("rm_bit3", 32'(uart_txd), 32'd0);
    chk("rm_count1", 32'(fifo_count), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("rm_txd", 32'(uart_txd), 32'd1);
    chk("rm_count0", 32'(fifo_count), 32'd0);
    chk("rm_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    lows = 0;
    repeat (300) begin
      tick(1);
      if (uart_txd !== 1'b1) lows++;
    end
    chk("rm_no_frames", 32'(lows), 32'd0);
    chk("rm_count_after", 32'(fifo_count), 32'd0);

    // 7 data bits, 2 stop bits: 0x7F then 0x00
    tx_en2 = 1'b1;
    tx_valid2 = 1'b1; tx_data2 = 7'h7F;
    tick(1);
    tx_data2 = 7'h00;
    tick(1);
    tx_valid2 = 1'b0;
    chk("s2_start", 32'(txd2), 32'd0);
    rx_frame(2, 7, 2, 0, b);
    chk("s2_byte0", 32'(b), 32'h7F);
    tick(4);
    chk("s2_stop_end", 32'(txd2), 32'd1);
    tick(1);
    chk("s2_load", 32'(txd2), 32'd1);
    tick(1);
    chk("s2_start2", 32'(txd2), 32'd0);
    chk("s2_count", 32'(count2), 32'd0);
    rx_frame(2, 7, 2, 0, b);
    chk("s2_byte1", 32'(b), 32'h00);
    tick(6);
    chk("s2_idle", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
